// File: rtl/pix_pkg.sv
// Shared pixel types and BT.601-style luma constants for the pixel path.
package pix_pkg;

  localparam int LUMA_COEF_R = 77;
  localparam int LUMA_COEF_G = 150;
  localparam int LUMA_COEF_B = 29;
  localparam int LUMA_ROUND  = 128;

  typedef logic [7:0] pix8_t;

  typedef struct packed {
    pix8_t r;
    pix8_t g;
    pix8_t b;
  } rgb888_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO, synchronous active-high reset.
// A push while full is accepted only when a pop frees the head slot in the same cycle.
module sync_fifo_fwft #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
)(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Head reads as zero when empty so no stale word is ever visible.
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/rgb_gray_fifo.sv
// RGB888 -> 8-bit luma, 3-stage non-stalling pipeline feeding a FWFT FIFO.
// Define DROP_CNT_EN to add the saturating drop_cnt port.
module rgb_gray_fifo
  import pix_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int COEF_R     = LUMA_COEF_R,
  parameter int COEF_G     = LUMA_COEF_G,
  parameter int COEF_B     = LUMA_COEF_B
)(
  input  logic                          sys_clk,
  input  logic                          sys_rst,
  input  logic                          pix_in_valid,
  input  logic [7:0]                    r_in,
  input  logic [7:0]                    g_in,
  input  logic [7:0]                    b_in,
  output logic [7:0]                    gray_out,
  output logic                          gray_valid,
  input  logic                          gray_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  input  logic                          ovf_clear
`ifdef DROP_CNT_EN
  ,
  output logic [15:0]                   drop_cnt
`endif
);

  localparam logic [15:0] CR = 16'(COEF_R);
  localparam logic [15:0] CG = 16'(COEF_G);
  localparam logic [15:0] CB = 16'(COEF_B);

  rgb888_t     px;
  logic [1:0]  vld_pipe;
  logic [15:0] pr, pg, pb;
  logic [16:0] sum;
  pix8_t       luma;
  logic        fifo_full, fifo_empty, drop;
  logic        sum_unused;

  assign px = '{r: r_in, g: g_in, b: b_in};

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      vld_pipe <= '0;
      pr       <= '0;
      pg       <= '0;
      pb       <= '0;
      sum      <= '0;
    end else begin
      vld_pipe <= {vld_pipe[0], pix_in_valid};
      pr       <= CR * {8'd0, px.r};
      pg       <= CG * {8'd0, px.g};
      pb       <= CB * {8'd0, px.b};
      sum      <= {1'b0, pr} + {1'b0, pg} + {1'b0, pb} + 17'(LUMA_ROUND);
    end
  end

  // Weights sum to 256, so the rounded sum never exceeds 65408 and bits [15:8] hold the luma.
  assign luma       = sum[15:8];
  assign sum_unused = ^{sum[16], sum[7:0]};

  sync_fifo_fwft #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (sys_clk),
    .rst   (sys_rst),
    .push  (vld_pipe[1]),
    .din   (luma),
    .pop   (gray_ready),
    .dout  (gray_out),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign gray_valid = !fifo_empty;
  assign drop       = vld_pipe[1] && fifo_full && !gray_ready;

  // A drop in the clear cycle wins over the clear.
  always_ff @(posedge sys_clk) begin
    if (sys_rst)        overflow <= 1'b0;
    else if (drop)      overflow <= 1'b1;
    else if (ovf_clear) overflow <= 1'b0;
  end

`ifdef DROP_CNT_EN
  always_ff @(posedge sys_clk) begin
    if (sys_rst)             drop_cnt <= '0;
    else if (drop) begin
      if (ovf_clear)         drop_cnt <= 16'd1;
      else if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 1'b1;
    end
    else if (ovf_clear)      drop_cnt <= '0;
  end
`endif

endmodule

// File: tb/tb_rgb_gray_fifo.sv
// Directed self-checking bench for rgb_gray_fifo (FIFO_DEPTH=16), with drop_cnt checks under DROP_CNT_EN.
module tb_rgb_gray_fifo;

  logic       sys_clk = 1'b0;
  logic       sys_rst, pix_in_valid, gray_ready, ovf_clear;
  logic [7:0] r_in, g_in, b_in, gray_out;
  logic       gray_valid, overflow;
  logic [4:0] fifo_level;
`ifdef DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  rgb_gray_fifo #(.FIFO_DEPTH(16)) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .pix_in_valid (pix_in_valid),
    .r_in         (r_in),
    .g_in         (g_in),
    .b_in         (b_in),
    .gray_out     (gray_out),
    .gray_valid   (gray_valid),
    .gray_ready   (gray_ready),
    .fifo_level   (fifo_level),
    .overflow     (overflow),
    .ovf_clear    (ovf_clear)
`ifdef DROP_CNT_EN
    ,
    .drop_cnt     (drop_cnt)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic pix(input logic v, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    pix_in_valid = v;
    r_in = r;
    g_in = g;
    b_in = b;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    sys_rst = 1'b1; gray_ready = 1'b0; ovf_clear = 1'b0;
    pix(1'b0, 8'd0, 8'd0, 8'd0);
    tick(); tick();
    check("rst_valid", {31'd0, gray_valid}, 0);
    check("rst_out",   {24'd0, gray_out}, 0);
    check("rst_level", {27'd0, fifo_level}, 0);
    check("rst_ovf",   {31'd0, overflow}, 0);
`ifdef DROP_CNT_EN
    check("rst_dcnt",  {16'd0, drop_cnt}, 0);
`endif
    sys_rst = 1'b0;

    // White pixel: 3-cycle latency, then popped.
    gray_ready = 1'b1;
    pix(1'b1, 8'd255, 8'd255, 8'd255);
    check("lat_c0", {31'd0, gray_valid}, 0);
    tick(); pix(1'b0, 8'd0, 8'd0, 8'd0);
    check("lat_c1", {31'd0, gray_valid}, 0);
    tick();
    check("lat_c2", {31'd0, gray_valid}, 0);
    tick();
    check("lat_c3_valid", {31'd0, gray_valid}, 1);
    check("lat_c3_out",   {24'd0, gray_out}, 255);
    tick();
    check("lat_c4_valid", {31'd0, gray_valid}, 0);

    // Four back-to-back pixels, ready high: 0, 82, 77, 29.
    pix(1'b1, 8'd0,   8'd0,  8'd0);   tick();
    pix(1'b1, 8'd100, 8'd50, 8'd200); tick();
    pix(1'b1, 8'd255, 8'd0,  8'd0);   tick();
    pix(1'b1, 8'd0,   8'd0,  8'd255);
    check("b2b_out0", {24'd0, gray_out}, 0);
    check("b2b_lvl0", {27'd0, fifo_level}, 1);
    tick(); pix(1'b0, 8'd0, 8'd0, 8'd0);
    check("b2b_out1", {24'd0, gray_out}, 82);
    check("b2b_lvl1", {27'd0, fifo_level}, 1);
    tick();
    check("b2b_out2", {24'd0, gray_out}, 77);
    check("b2b_lvl2", {27'd0, fifo_level}, 1);
    tick();
    check("b2b_out3", {24'd0, gray_out}, 29);
    check("b2b_val3", {31'd0, gray_valid}, 1);
    tick();
    check("b2b_empty", {31'd0, gray_valid}, 0);

    // 17 gray pixels (v,v,v -> luma v) into a stalled sink: one drop.
    gray_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      pix(1'b1, 8'(i + 1), 8'(i + 1), 8'(i + 1));
      tick();
    end
    pix(1'b0, 8'd0, 8'd0, 8'd0);
    tick();
    check("ovf_pre_lvl", {27'd0, fifo_level}, 16);
    check("ovf_pre_ovf", {31'd0, overflow}, 0);
    tick();
    check("ovf_lvl", {27'd0, fifo_level}, 16);
    check("ovf_set", {31'd0, overflow}, 1);
`ifdef DROP_CNT_EN
    check("ovf_dcnt", {16'd0, drop_cnt}, 1);
`endif
    gray_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("drain_out", {24'd0, gray_out}, 32'(i + 1));
      tick();
    end
    check("drain_empty", {31'd0, gray_valid}, 0);
    check("drain_ovf",   {31'd0, overflow}, 1);

    // Clear with no drop.
    ovf_clear = 1'b1; tick(); ovf_clear = 1'b0;
    check("clr_ovf", {31'd0, overflow}, 0);
`ifdef DROP_CNT_EN
    check("clr_dcnt", {16'd0, drop_cnt}, 0);
`endif

    // Fill to full, then stream with ready aligned to writes: level holds at 16.
    gray_ready = 1'b0;
    for (int k = 0; k < 26; k++) begin
      if (k < 24) pix(1'b1, 8'(101 + k), 8'(101 + k), 8'(101 + k));
      else        pix(1'b0, 8'd0, 8'd0, 8'd0);
      gray_ready = (k >= 18);
      if (k >= 18) begin
        check("full_lvl",  {27'd0, fifo_level}, 16);
        check("full_head", {24'd0, gray_out}, 32'(101 + k - 18));
      end
      tick();
    end
    check("full_lvl_end", {27'd0, fifo_level}, 16);
    check("full_noovf",   {31'd0, overflow}, 0);
    for (int i = 0; i < 16; i++) begin
      check("full_drain", {24'd0, gray_out}, 32'(109 + i));
      tick();
    end
    check("full_empty", {27'd0, fifo_level}, 0);

    // Drop in the same cycle as ovf_clear: set wins.
    gray_ready = 1'b0;
    for (int k = 0; k < 19; k++) begin
      if (k < 17) pix(1'b1, 8'(k + 1), 8'(k + 1), 8'(k + 1));
      else        pix(1'b0, 8'd0, 8'd0, 8'd0);
      ovf_clear = (k == 18);
      tick();
    end
    ovf_clear = 1'b0;
    check("setwin_ovf", {31'd0, overflow}, 1);
`ifdef DROP_CNT_EN
    check("setwin_dcnt", {16'd0, drop_cnt}, 1);
`endif

    // Mid-operation reset: 5 in FIFO, 2 in flight.
    sys_rst = 1'b1; tick(); sys_rst = 1'b0;
    for (int k = 0; k < 7; k++) begin
      pix(1'b1, 8'(50 + k), 8'(50 + k), 8'(50 + k));
      tick();
    end
    pix(1'b0, 8'd0, 8'd0, 8'd0);
    check("mrst_pre_lvl", {27'd0, fifo_level}, 5);
    sys_rst = 1'b1; tick(); sys_rst = 1'b0;
    check("mrst_lvl",   {27'd0, fifo_level}, 0);
    check("mrst_valid", {31'd0, gray_valid}, 0);
    check("mrst_out",   {24'd0, gray_out}, 0);
    check("mrst_ovf",   {31'd0, overflow}, 0);
    gray_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("mrst_stale", {31'd0, gray_valid}, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rgb_gray_fifo.md
Name: rgb_gray_fifo

Overview:
- Downstream stage of the byte-to-RGB packer: consumes its r/g/b triplet and one-cycle ready pulse.
- Converts each RGB888 pixel to 8-bit luma via a 3-stage fixed-point pipeline.
- Buffers results in a first-word-fall-through FIFO behind a valid/ready output handshake.
- The upstream packer has no backpressure, so the FIFO absorbs sink stalls and reports drops.

Parameters:
- FIFO_DEPTH, 16, FIFO entries; power of 2, >=2
- COEF_R, 77, red weight (Q0.8)
- COEF_G, 150, green weight (Q0.8)
- COEF_B, 29, blue weight (Q0.8); COEF_R+COEF_G+COEF_B must equal 256

Ports:
- sys_clk  in  1  clock; all logic on rising edge
- sys_rst  in  1  synchronous reset, active-high
- pix_in_valid  in  1  one-cycle pixel strobe (upstream data_out_ready)
- r_in  in  8  red
- g_in  in  8  green
- b_in  in  8  blue
- gray_out  out  8  luma at FIFO head
- gray_valid  out  1  FIFO non-empty
- gray_ready  in  1  sink accepts gray_out when gray_valid & gray_ready
- fifo_level  out  $clog2(FIFO_DEPTH)+1  entries held
- overflow  out  1  sticky: a pixel was dropped
- ovf_clear  in  1  clears overflow
- drop_cnt  out  16  dropped-pixel count; present only with DROP_CNT_EN

Behaviour:
- Interface is one clock, sys_clk; reset sys_rst is synchronous and active-high.
- Reset values: gray_out=0, gray_valid=0, fifo_level=0, overflow=0, drop_cnt=0, all pipeline valids=0.
- The FIFO is emptied by reset.
- Pipeline never stalls; every pix_in_valid pixel enters it.
- S1 (edge 0): register products pr=COEF_R*r, pg=COEF_G*g, pb=COEF_B*b (16 bit each), plus v1.
- S2 (edge 1): sum = pr+pg+pb+128 (17 bit, max 65408), plus v2.
- S3 (edge 2): write sum[15:8] to the FIFO if v2; rounding is round-half-up; result is never >255.
- Latency: pix_in_valid in cycle 0 with FIFO empty -> gray_valid=1 and gray_out valid in cycle 3.
- Back-to-back pixels every cycle are supported at full throughput.
- Read: when gray_valid & gray_ready, the head pops at the edge; the next entry appears the following cycle.
- gray_ready while empty is ignored.
- Write with FIFO not full: stored.
- Write with FIFO full and no pop in the same cycle: pixel dropped, overflow<=1, drop_cnt increments.
- Write and pop in the same cycle while full: both succeed; level stays at FIFO_DEPTH; no drop.
- Write and pop in the same cycle while level=1: level stays at 1; the new word becomes head next cycle.
- fifo_level is registered, updated +1/-1/0 per the above; it equals FIFO_DEPTH when full.
- Read/write pointers are $clog2(FIFO_DEPTH) bits and wrap naturally.
- ovf_clear: overflow<=0, unless a drop occurs in the same cycle; then overflow stays 1 (set wins).
- Reset mid-operation: in-flight S1/S2 pixels are discarded, the FIFO is emptied, and outputs take reset values on the next cycle.

Optional Feature:
- DROP_CNT_EN defined: port drop_cnt exists.
  - It is a 16-bit counter incrementing on each dropped pixel and saturating at 65535.
  - ovf_clear also zeroes it (set-wins rule as for overflow; a drop in the clear cycle leaves it at 1).
- DROP_CNT_EN undefined: no drop_cnt port and no counter logic; everything else is unchanged.

Decomposition:
- Shared package pix_pkg holds:
  - luma coefficient defaults LUMA_COEF_R/G/B = 77/150/29
  - LUMA_ROUND = 128
  - typedef pix8_t (8-bit channel)
  - typedef rgb888_t (struct r,g,b)
- One sub-module, sync_fifo_fwft: parameterised width/depth, synchronous reset, push/pop/full/empty/level.
- The top holds the pipeline and the overflow/drop logic.

Test Plan:
- Reset, then pixel (255,255,255) with gray_ready=1 -> gray_valid high exactly 3 cycles later, gray_out=255, then gray_valid=0.
- Pixels (0,0,0), (100,50,200), (255,0,0), (0,0,255) on consecutive cycles, gray_ready=1 -> gray_out 0, 82, 77, 29 on 4 consecutive cycles.
- gray_ready=0, 17 pixels with FIFO_DEPTH=16 -> fifo_level=16, overflow=1, drop_cnt=1 (DROP_CNT_EN); draining yields the first 16 values in order.
- FIFO full, gray_ready=1 and new pixels arriving every cycle -> level holds at 16, no drops, output order preserved.
- overflow=1, assert ovf_clear with no drop -> overflow=0; assert ovf_clear in the same cycle as a drop -> overflow stays 1.
- Assert sys_rst for 1 cycle while 2 pixels are in the pipeline and 5 in the FIFO -> next cycle level=0, gray_valid=0, gray_out=0; no stale output appears afterwards.
